// File: rtl/r16_ntt_agu_if.sv
// Radix-16 NTT address generation unit bus: control inputs and per-group index outputs.
interface r16_ntt_agu_if #(
    parameter int LOG_N   = 12,
    parameter int D_WIDTH = LOG_N - 4
);
    logic                   start;
    logic                   stall;
    logic [16*D_WIDTH-1:0]  ma_idx;
    logic [16*4-1:0]        bn_idx;
    logic                   ntt_enable;
    logic [1:0]             stage_idx;
    logic                   busy;
    logic                   ntt_done_agu;

    modport master (
        output start, stall,
        input  ma_idx, bn_idx, ntt_enable, stage_idx, busy, ntt_done_agu
    );

    modport slave (
        input  start, stall,
        output ma_idx, bn_idx, ntt_enable, stage_idx, busy, ntt_done_agu
    );
endinterface

// File: rtl/r16_ntt_agu.sv
// Radix-16 NTT address generation unit.
// Walks every (stage, group) of an N-point DIF transform and emits, per group, the
// 16 conflict-free (memory address, bank) pairs. The (s,g) pair is captured into a
// pipeline register first, and the index arithmetic feeds only the output registers,
// which gives a start-to-first-enable latency of two extra edges.
module r16_ntt_agu #(
    parameter int LOG_N   = 12,
    parameter int D_WIDTH = LOG_N - 4
) (
    input  logic            clk,
    input  logic            rst,
    r16_ntt_agu_if.slave    bus
);
    localparam int STAGES = LOG_N / 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        LAST = 2'd2
    } state_t;

    state_t                 state_r;
    state_t                 state_s;

    logic [1:0]             s_r;
    logic [D_WIDTH-1:0]     g_r;
    logic                   load_s;
    logic                   issue_s;
    logic                   drain_s;
    logic                   last_grp_s;

    logic                   p1_valid_r;
    logic                   p1_done_r;
    logic [1:0]             p1_s_r;
    logic [D_WIDTH-1:0]     p1_g_r;

    logic [LOG_N-1:0]       j_s;
    logic [16*D_WIDTH-1:0]  ma_nxt_s;
    logic [16*4-1:0]        bn_nxt_s;

    logic [16*D_WIDTH-1:0]  ma_r;
    logic [16*4-1:0]        bn_r;
    logic                   enable_r;
    logic [1:0]             stage_r;
    logic                   busy_r;
    logic                   done_r;

    // Data index of lane k: hex digit k inserted at digit position p = STAGES-1-s of g.
    function automatic logic [LOG_N-1:0] data_index(
        input logic [1:0]         s,
        input logic [D_WIDTH-1:0] g,
        input logic [3:0]         k
    );
        logic [LOG_N-1:0] gx;
        logic [LOG_N-1:0] mask;
        logic [LOG_N-1:0] lower;
        logic [LOG_N-1:0] upper;
        int               p;
        p = STAGES - 1 - int'(s);
        if (p < 0) begin
            p = 0;
        end else begin
            p = p;
        end
        gx    = LOG_N'(g);
        mask  = (LOG_N'(1) << (4 * p)) - LOG_N'(1);
        lower = gx & mask;
        upper = (gx >> (4 * p)) << (4 * p + 4);
        return upper | (LOG_N'(k) << (4 * p)) | lower;
    endfunction

    // Bank number: wrap-around 4-bit sum of all hex digits of the data index.
    function automatic logic [3:0] bank_of(input logic [LOG_N-1:0] j);
        logic [3:0] acc;
        acc = 4'd0;
        for (int i = 0; i < STAGES; i++) begin
            acc = acc + j[4*i +: 4];
        end
        return acc;
    endfunction

    assign last_grp_s = (s_r == 2'(STAGES - 1)) && (g_r == {D_WIDTH{1'b1}});

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.start) state_s = RUN;
                else           state_s = IDLE;
            end
            RUN: begin
                if (!bus.stall && last_grp_s) state_s = LAST;
                else                          state_s = RUN;
            end
            LAST:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // FSM control outputs: counter load, group issue and drain strobe.
    always_comb begin
        load_s  = 1'b0;
        issue_s = 1'b0;
        drain_s = 1'b0;
        case (state_r)
            IDLE:    load_s  = bus.start;
            RUN:     issue_s = !bus.stall;
            LAST:    drain_s = 1'b1;
            default: begin
                load_s  = 1'b0;
                issue_s = 1'b0;
                drain_s = 1'b0;
            end
        endcase
    end

    // Stage/group counters: cleared on start, advanced per issued group, frozen on the last one.
    always_ff @(posedge clk) begin
        if (!rst) begin
            s_r <= 2'd0;
            g_r <= '0;
        end else if (load_s) begin
            s_r <= 2'd0;
            g_r <= '0;
        end else if (issue_s && !last_grp_s) begin
            g_r <= g_r + D_WIDTH'(1);
            if (g_r == {D_WIDTH{1'b1}}) begin
                s_r <= s_r + 2'd1;
            end else begin
                s_r <= s_r;
            end
        end else begin
            s_r <= s_r;
            g_r <= g_r;
        end
    end

    // Pipeline register carrying the issued (s,g) and the drain strobe to the index stage.
    always_ff @(posedge clk) begin
        if (!rst) begin
            p1_valid_r <= 1'b0;
            p1_done_r  <= 1'b0;
            p1_s_r     <= 2'd0;
            p1_g_r     <= '0;
        end else begin
            p1_valid_r <= issue_s;
            p1_done_r  <= drain_s;
            if (issue_s) begin
                p1_s_r <= s_r;
                p1_g_r <= g_r;
            end else begin
                p1_s_r <= p1_s_r;
                p1_g_r <= p1_g_r;
            end
        end
    end

    // Index arithmetic for all 16 lanes of the pipelined group.
    always_comb begin
        j_s      = '0;
        ma_nxt_s = '0;
        bn_nxt_s = '0;
        for (int k = 0; k < 16; k++) begin
            j_s = data_index(p1_s_r, p1_g_r, 4'(k));
            ma_nxt_s[k*D_WIDTH +: D_WIDTH] = j_s[LOG_N-1:4];
            bn_nxt_s[k*4 +: 4]             = bank_of(j_s);
        end
    end

    // Output registers: indices update only for valid groups and hold otherwise.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ma_r     <= '0;
            bn_r     <= '0;
            stage_r  <= 2'd0;
            enable_r <= 1'b0;
            done_r   <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            enable_r <= p1_valid_r;
            done_r   <= p1_done_r;
            busy_r   <= (state_s != IDLE) || (state_r == LAST);
            if (p1_valid_r) begin
                ma_r    <= ma_nxt_s;
                bn_r    <= bn_nxt_s;
                stage_r <= p1_s_r;
            end else begin
                ma_r    <= ma_r;
                bn_r    <= bn_r;
                stage_r <= stage_r;
            end
        end
    end

    assign bus.ma_idx       = ma_r;
    assign bus.bn_idx       = bn_r;
    assign bus.stage_idx    = stage_r;
    assign bus.ntt_enable   = enable_r;
    assign bus.busy         = busy_r;
    assign bus.ntt_done_agu = done_r;
endmodule

// File: tb/tb_r16_ntt_agu.sv
// Self-checking bench for r16_ntt_agu against an arithmetic reference model.
module tb_r16_ntt_agu;
    localparam int LOG_N  = 12;
    localparam int DW     = LOG_N - 4;
    localparam int STAGES = LOG_N / 4;
    localparam int GROUPS = 1 << DW;
    localparam int TOTAL  = STAGES * GROUPS;
    localparam int MAW    = 16 * DW;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    int   hits [STAGES][16][GROUPS];

    r16_ntt_agu_if #(.LOG_N(LOG_N)) bus ();

    r16_ntt_agu #(.LOG_N(LOG_N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: data index as plain base-16 arithmetic with digit k inserted at position p.
    function automatic int ref_j(int s, int g, int k);
        int w;
        w = 16 ** (STAGES - 1 - s);
        return (g / w) * w * 16 + k * w + (g % w);
    endfunction

    function automatic logic [MAW-1:0] ref_ma(int s, int g);
        logic [MAW-1:0] v;
        v = '0;
        for (int k = 0; k < 16; k++) v[k*DW +: DW] = DW'(ref_j(s, g, k) / 16);
        return v;
    endfunction

    function automatic logic [63:0] ref_bn(int s, int g);
        logic [63:0] v;
        int t;
        int sum;
        v = '0;
        for (int k = 0; k < 16; k++) begin
            t = ref_j(s, g, k);
            sum = 0;
            for (int d = 0; d < STAGES; d++) begin
                sum += t % 16;
                t = t / 16;
            end
            v[k*4 +: 4] = 4'(sum % 16);
        end
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.start = 1'b1;
        bus.stall = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({bus.ntt_enable, bus.ntt_done_agu, bus.busy, bus.stage_idx} !== 5'd0 ||
                bus.ma_idx !== '0 || bus.bn_idx !== '0) begin
                failures++;
                $display("FAIL reset_outputs cyc=%0d en=%b done=%b busy=%b stage=%0d ma=%h bn=%h required all 0",
                         i, bus.ntt_enable, bus.ntt_done_agu, bus.busy, bus.stage_idx, bus.ma_idx, bus.bn_idx);
            end
        end
        bus.start = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus.busy !== 1'b0 || bus.ntt_enable !== 1'b0) begin
                failures++;
                $display("FAIL reset_idle busy=%b en=%b required 0 0", bus.busy, bus.ntt_enable);
            end
        end
    endtask

    task automatic test_full_run();
        int en_cnt;
        int s;
        int g;
        int bad;
        logic [15:0]    seen;
        logic [MAW-1:0] kv_ma;
        logic [63:0]    kv_bn;
        for (int a = 0; a < STAGES; a++)
            for (int b = 0; b < 16; b++)
                for (int c = 0; c < GROUPS; c++) hits[a][b][c] = 0;
        en_cnt = 0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        checks++;
        if (bus.busy !== 1'b1 || bus.ntt_enable !== 1'b0) begin
            failures++;
            $display("FAIL full_start busy=%b en=%b required 1 0", bus.busy, bus.ntt_enable);
        end
        tick();
        checks++;
        if (bus.ntt_enable !== 1'b0) begin
            failures++;
            $display("FAIL full_latency_early en=%b required 0", bus.ntt_enable);
        end
        tick();
        while (bus.ntt_enable === 1'b1 && en_cnt < TOTAL + 4) begin
            s = en_cnt / GROUPS;
            g = en_cnt % GROUPS;
            checks++;
            if (bus.ma_idx !== ref_ma(s, g) || bus.bn_idx !== ref_bn(s, g) || bus.stage_idx !== 2'(s)) begin
                failures++;
                $display("FAIL full_group s=%0d g=%0d ma=%h bn=%h stage=%0d required ma=%h bn=%h stage=%0d",
                         s, g, bus.ma_idx, bus.bn_idx, bus.stage_idx, ref_ma(s, g), ref_bn(s, g), s);
            end
            seen = 16'h0000;
            for (int k = 0; k < 16; k++) begin
                seen[bus.bn_idx[k*4 +: 4]] = 1'b1;
                if (s < STAGES) hits[s][bus.bn_idx[k*4 +: 4]][bus.ma_idx[k*DW +: DW]]++;
            end
            checks++;
            if (seen !== 16'hFFFF) begin
                failures++;
                $display("FAIL full_bank_perm s=%0d g=%0d banks=%h required ffff", s, g, seen);
            end
            if (en_cnt == 0 || en_cnt == GROUPS + 255 || en_cnt == 2 * GROUPS + 18) begin
                for (int k = 0; k < 16; k++) begin
                    if (en_cnt == 0) begin
                        kv_ma[k*DW +: DW] = DW'(16 * k);
                        kv_bn[k*4 +: 4]   = 4'(k);
                    end else if (en_cnt == GROUPS + 255) begin
                        kv_ma[k*DW +: DW] = DW'(240 + k);
                        kv_bn[k*4 +: 4]   = 4'((14 + k) % 16);
                    end else begin
                        kv_ma[k*DW +: DW] = DW'(18);
                        kv_bn[k*4 +: 4]   = 4'((3 + k) % 16);
                    end
                end
                checks++;
                if (bus.ma_idx !== kv_ma || bus.bn_idx !== kv_bn) begin
                    failures++;
                    $display("FAIL known_vector n=%0d ma=%h bn=%h required ma=%h bn=%h",
                             en_cnt, bus.ma_idx, bus.bn_idx, kv_ma, kv_bn);
                end
            end
            en_cnt++;
            tick();
        end
        checks++;
        if (en_cnt != TOTAL) begin
            failures++;
            $display("FAIL full_enable_count got=%0d required %0d", en_cnt, TOTAL);
        end
        checks++;
        if (bus.ntt_done_agu !== 1'b1) begin
            failures++;
            $display("FAIL full_done_pulse done=%b required 1", bus.ntt_done_agu);
        end
        tick();
        checks++;
        if (bus.ntt_done_agu !== 1'b0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL full_after_done done=%b busy=%b required 0 0", bus.ntt_done_agu, bus.busy);
        end
        bad = 0;
        for (int a = 0; a < STAGES; a++)
            for (int b = 0; b < 16; b++)
                for (int c = 0; c < GROUPS; c++)
                    if (hits[a][b][c] != 1) bad++;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL full_bank_ma_coverage bad_pairs=%0d required 0", bad);
        end
    endtask

    task automatic test_stall();
        int en_cnt;
        int dones;
        int s;
        int g;
        logic [MAW-1:0] last_ma;
        logic [63:0]    last_bn;
        en_cnt = 0;
        dones = 0;
        last_ma = '0;
        last_bn = '0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int cyc = 0; cyc < 6000 && dones == 0; cyc++) begin
            bus.stall = ($urandom_range(99) < 30);
            bus.start = (cyc == 150);
            tick();
            if (bus.ntt_enable === 1'b1) begin
                s = en_cnt / GROUPS;
                g = en_cnt % GROUPS;
                checks++;
                if (bus.ma_idx !== ref_ma(s, g) || bus.bn_idx !== ref_bn(s, g) || bus.stage_idx !== 2'(s)) begin
                    failures++;
                    $display("FAIL stall_group s=%0d g=%0d ma=%h bn=%h stage=%0d required ma=%h bn=%h stage=%0d",
                             s, g, bus.ma_idx, bus.bn_idx, bus.stage_idx, ref_ma(s, g), ref_bn(s, g), s);
                end
                last_ma = ref_ma(s, g);
                last_bn = ref_bn(s, g);
                en_cnt++;
            end else if (bus.ntt_done_agu === 1'b1) begin
                dones++;
            end else if (en_cnt > 0) begin
                checks++;
                if (bus.ma_idx !== last_ma || bus.bn_idx !== last_bn) begin
                    failures++;
                    $display("FAIL stall_hold n=%0d ma=%h bn=%h required ma=%h bn=%h",
                             en_cnt, bus.ma_idx, bus.bn_idx, last_ma, last_bn);
                end
            end
        end
        bus.stall = 1'b0;
        bus.start = 1'b0;
        checks++;
        if (en_cnt != TOTAL || dones != 1) begin
            failures++;
            $display("FAIL stall_totals enables=%0d dones=%0d required %0d 1", en_cnt, dones, TOTAL);
        end
        tick();
        checks++;
        if (bus.busy !== 1'b0 || bus.ntt_done_agu !== 1'b0) begin
            failures++;
            $display("FAIL stall_after_done busy=%b done=%b required 0 0", bus.busy, bus.ntt_done_agu);
        end
    endtask

    task automatic test_abort();
        int en_cnt;
        int seen_bad;
        en_cnt = 0;
        seen_bad = 0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int cyc = 0; cyc < 2000 && en_cnt < 400; cyc++) begin
            tick();
            if (bus.ntt_enable === 1'b1) en_cnt++;
        end
        checks++;
        if (en_cnt != 400) begin
            failures++;
            $display("FAIL abort_reach_400 enables=%0d required 400", en_cnt);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (bus.ntt_enable !== 1'b0 || bus.busy !== 1'b0 || bus.ma_idx !== '0 || bus.bn_idx !== '0) begin
            failures++;
            $display("FAIL abort_reset_clear en=%b busy=%b ma=%h bn=%h required 0", bus.ntt_enable, bus.busy, bus.ma_idx, bus.bn_idx);
        end
        tick();
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.ntt_done_agu !== 1'b0 || bus.ntt_enable !== 1'b0 || bus.busy !== 1'b0) seen_bad++;
        end
        checks++;
        if (seen_bad != 0) begin
            failures++;
            $display("FAIL abort_quiet active_cycles=%0d required 0", seen_bad);
        end
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        checks++;
        if (bus.ntt_enable !== 1'b0) begin
            failures++;
            $display("FAIL abort_restart_early en=%b required 0", bus.ntt_enable);
        end
        tick();
        checks++;
        if (bus.ntt_enable !== 1'b1 || bus.stage_idx !== 2'd0 ||
            bus.ma_idx !== ref_ma(0, 0) || bus.bn_idx !== ref_bn(0, 0)) begin
            failures++;
            $display("FAIL abort_restart_first en=%b stage=%0d ma=%h bn=%h required 1 0 ma=%h bn=%h",
                     bus.ntt_enable, bus.stage_idx, bus.ma_idx, bus.bn_idx, ref_ma(0, 0), ref_bn(0, 0));
        end
        for (int cyc = 0; cyc < 2000 && bus.ntt_done_agu !== 1'b1; cyc++) tick();
        checks++;
        if (bus.ntt_done_agu !== 1'b1) begin
            failures++;
            $display("FAIL abort_restart_done done=%b required 1", bus.ntt_done_agu);
        end
        tick();
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b0;
        bus.start = 1'b0;
        bus.stall = 1'b0;
        test_reset();
        test_full_run();
        test_stall();
        test_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
